// File: rtl/cacheline_responder.sv
// Cacheline-to-burst adapter: splits a line read or write-back into
// four downstream beats, low beat first, and pulses pmem_resp when done.
module cacheline_responder #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [ADDR_W-1:0]  pmem_address,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic               burst_read,
    output logic               burst_write,
    output logic [ADDR_W-1:0]  burst_address,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF   = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t                         state, state_n;
    logic [CNT_W-1:0]               cnt, cnt_n;
    logic [ADDR_W-1:0]              addr_q, addr_n;
    logic [BEATS-1:0][BURST_W-1:0]  line_q, line_n;
    logic [BEATS-1:0][BURST_W-1:0]  rdata_q, rdata_n;
    logic [ADDR_W-1:0]              aligned;
    logic                           last;

    assign aligned = {pmem_address[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign last    = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            line_q  <= line_n;
            rdata_q <= rdata_n;
        end
    end

    // line_q holds the write-back line or the read line being assembled
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        addr_n      = addr_q;
        line_n      = line_q;
        rdata_n     = rdata_q;
        pmem_resp   = 1'b0;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        burst_wdata = '0;
        unique case (state)
            IDLE: begin
                if (pmem_write) begin
                    addr_n  = aligned;
                    line_n  = pmem_wdata;
                    cnt_n   = '0;
                    state_n = WR_BURST;
                end else if (pmem_read) begin
                    addr_n  = aligned;
                    cnt_n   = '0;
                    state_n = RD_BURST;
                end
            end
            RD_BURST: begin
                burst_read = 1'b1;
                if (burst_resp) begin
                    line_n[cnt] = burst_rdata;
                    cnt_n       = cnt + 1'b1;
                    if (last) begin
                        rdata_n = line_n;
                        state_n = DONE;
                    end
                end
            end
            WR_BURST: begin
                burst_write = 1'b1;
                burst_wdata = line_q[cnt];
                if (burst_resp) begin
                    cnt_n = cnt + 1'b1;
                    if (last) state_n = DONE;
                end
            end
            DONE: begin
                pmem_resp = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign burst_address = addr_q;
    assign pmem_rdata    = rdata_q;

endmodule
